// File: rtl/imem_arbiter.sv
// Purpose : shares the single-read-port instruction memory between fetch (F) and debug (D) readers.
// Latency : request accepted in cycle N, read data presented to that requester in cycle N+1.
// Backpress: each port owns a 1-entry hold register; a port that has not drained its response is not granted.
//
// Ports:
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   f_req_* / f_rsp_*        fetch request (valid/ready/addr) and response (valid/ready/data)
//   d_req_* / d_rsp_*        debug request (valid/ready/addr) and response (valid/ready/data)
//   mem_addr_o               word address to the memory, sampled by it at posedge
//   mem_rdata_i              memory read data, valid the cycle after the address
module imem_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int DBG_MAX_WAIT = 4,
    parameter int WAIT_W       = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,

    input  logic              f_req_valid_i,
    output logic              f_req_ready_o,
    input  logic [ADDR_W-1:0] f_req_addr_i,
    output logic              f_rsp_valid_o,
    output logic [DATA_W-1:0] f_rsp_data_o,
    input  logic              f_rsp_ready_i,

    input  logic              d_req_valid_i,
    output logic              d_req_ready_o,
    input  logic [ADDR_W-1:0] d_req_addr_i,
    output logic              d_rsp_valid_o,
    output logic [DATA_W-1:0] d_rsp_data_o,
    input  logic              d_rsp_ready_i,

    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    // Per-port response tracking:
    //   RSP_EMPTY    nothing outstanding
    //   RSP_INFLIGHT accepted last cycle, data is on mem_rdata_i right now
    //   RSP_HELD     data parked in the port's hold register
    typedef enum logic [1:0] {
        RSP_EMPTY    = 2'd0,
        RSP_INFLIGHT = 2'd1,
        RSP_HELD     = 2'd2
    } rsp_state_e;

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DBG_MAX_WAIT);

    rsp_state_e        f_state_q, f_state_d;
    rsp_state_e        d_state_q, d_state_d;
    logic [DATA_W-1:0] f_hold_q;
    logic [DATA_W-1:0] d_hold_q;
    logic              f_hold_ld;
    logic              d_hold_ld;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic              f_elig;
    logic              d_elig;
    logic              f_win;
    logic              d_win;

    // Next response state for one port. A port can only be accepted while
    // EMPTY or while its current response drains, so a grant never collides
    // with an undrained response.
    function automatic rsp_state_e rsp_next(input rsp_state_e cur,
                                            input logic       rsp_rdy,
                                            input logic       accept);
        rsp_state_e nxt;
        nxt = RSP_EMPTY;
        case (cur)
            RSP_EMPTY: begin
                nxt = accept ? RSP_INFLIGHT : RSP_EMPTY;
            end
            RSP_INFLIGHT, RSP_HELD: begin
                if (rsp_rdy) begin
                    nxt = accept ? RSP_INFLIGHT : RSP_EMPTY;
                end else begin
                    nxt = RSP_HELD;
                end
            end
            default: begin
                nxt = RSP_EMPTY;
            end
        endcase
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // Eligible = has a request and the previous response is gone or leaving
    // this cycle; this keeps one read per cycle per port at full rate.
    always_comb begin
        f_elig = f_req_valid_i && ((f_state_q == RSP_EMPTY) || f_rsp_ready_i);
        d_elig = d_req_valid_i && ((d_state_q == RSP_EMPTY) || d_rsp_ready_i);

        // Fetch has priority unless debug has already lost WAIT_MAX times
        // in a row; with WAIT_MAX == 0 debug wins every contested cycle.
        // No grants at all while reset is asserted.
        d_win = rst_n_i && d_elig && (!f_elig || (wait_cnt_q == WAIT_MAX));
        f_win = rst_n_i && f_elig && !d_win;
    end

    // Consecutive-loss counter for debug. Holds its value while debug is
    // requesting but ineligible (waiting on its own response to drain).
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!d_req_valid_i || d_win) begin
            wait_cnt_d = '0;
        end else if (d_elig && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Response state next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        f_state_d = rsp_next(f_state_q, f_rsp_ready_i, f_win);
        d_state_d = rsp_next(d_state_q, d_rsp_ready_i, d_win);

        // Memory data only lives for one cycle, so an unaccepted in-flight
        // word must be captured now.
        f_hold_ld = (f_state_q == RSP_INFLIGHT) && !f_rsp_ready_i;
        d_hold_ld = (d_state_q == RSP_INFLIGHT) && !d_rsp_ready_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            f_state_q  <= RSP_EMPTY;
            d_state_q  <= RSP_EMPTY;
            wait_cnt_q <= '0;
        end else begin
            f_state_q  <= f_state_d;
            d_state_q  <= d_state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            f_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            if (f_hold_ld) begin
                f_hold_q <= mem_rdata_i;
            end
            if (d_hold_ld) begin
                d_hold_q <= mem_rdata_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        f_req_ready_o = f_win;
        d_req_ready_o = d_win;

        // With no winner the fetch address is still driven so the memory
        // input is deterministic; that read is simply never routed back.
        mem_addr_o = d_win ? d_req_addr_i : f_req_addr_i;

        f_rsp_valid_o = 1'b0;
        f_rsp_data_o  = '0;
        case (f_state_q)
            RSP_INFLIGHT: begin
                f_rsp_valid_o = 1'b1;
                f_rsp_data_o  = mem_rdata_i;
            end
            RSP_HELD: begin
                f_rsp_valid_o = 1'b1;
                f_rsp_data_o  = f_hold_q;
            end
            default: begin
                f_rsp_valid_o = 1'b0;
                f_rsp_data_o  = '0;
            end
        endcase

        d_rsp_valid_o = 1'b0;
        d_rsp_data_o  = '0;
        case (d_state_q)
            RSP_INFLIGHT: begin
                d_rsp_valid_o = 1'b1;
                d_rsp_data_o  = mem_rdata_i;
            end
            RSP_HELD: begin
                d_rsp_valid_o = 1'b1;
                d_rsp_data_o  = d_hold_q;
            end
            default: begin
                d_rsp_valid_o = 1'b0;
                d_rsp_data_o  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Purpose : drives two arbiters (debug wait limit 4 and 0) with the same requests and compares to a reference model.
// Latency : model expects each granted read's word one cycle after the grant.
// Backpress: random response-ready deassertion exercises the per-port hold path.
module tb_imem_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          rst_n_i;
    logic          f_vld, f_rrdy, d_vld, d_rrdy;
    logic [AW-1:0] f_addr, d_addr;

    logic          f_rdy [2];
    logic          d_rdy [2];
    logic          f_rv  [2];
    logic          d_rv  [2];
    logic [DW-1:0] f_rd  [2];
    logic [DW-1:0] d_rd  [2];
    logic [AW-1:0] maddr [2];
    logic [DW-1:0] rdata [2];

    logic [DW-1:0] mem [0:(1<<AW)-1];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        imem_arbiter #(
            .ADDR_W      (AW),
            .DATA_W      (DW),
            .DBG_MAX_WAIT((k == 0) ? 4 : 0),
            .WAIT_W      (3)
        ) u_dut (
            .clk_i        (clk_i),
            .rst_n_i      (rst_n_i),
            .f_req_valid_i(f_vld),
            .f_req_ready_o(f_rdy[k]),
            .f_req_addr_i (f_addr),
            .f_rsp_valid_o(f_rv[k]),
            .f_rsp_data_o (f_rd[k]),
            .f_rsp_ready_i(f_rrdy),
            .d_req_valid_i(d_vld),
            .d_req_ready_o(d_rdy[k]),
            .d_req_addr_i (d_addr),
            .d_rsp_valid_o(d_rv[k]),
            .d_rsp_data_o (d_rd[k]),
            .d_rsp_ready_i(d_rrdy),
            .mem_addr_o   (maddr[k]),
            .mem_rdata_i  (rdata[k])
        );

        // Synchronous-read memory model, one per instance.
        always @(posedge clk_i) rdata[k] <= mem[maddr[k]];
    end

    // Reference model: per instance, per port (0=F, 1=D) an outstanding
    // response flag plus the word it must deliver, and debug's loss streak.
    int            maxw [2] = '{4, 0};
    bit            pend [2][2];
    logic [DW-1:0] pdat [2][2];
    int            losses [2];
    bit            g_f [2];
    bit            g_d [2];
    bit            d_ok [2];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit fv, input int fa, input bit fr,
                          input bit dv, input int da, input bit dr);
        f_vld  = fv;
        f_addr = AW'(fa);
        f_rrdy = fr;
        d_vld  = dv;
        d_addr = AW'(da);
        d_rrdy = dr;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            pend[k][0] = 1'b0;
            pend[k][1] = 1'b0;
            pdat[k][0] = '0;
            pdat[k][1] = '0;
            losses[k]  = 0;
            g_f[k]     = 1'b0;
            g_d[k]     = 1'b0;
        end
    endtask

    // One clock cycle: inputs already applied, compare outputs mid-cycle,
    // cross the edge, then advance the model.
    task automatic step();
        #1;
        for (int k = 0; k < 2; k++) begin
            bit            fok;
            bit            dok;
            bit            dw;
            bit            fw;
            logic [AW-1:0] ea;
            fok = f_vld && (!pend[k][0] || f_rrdy);
            dok = d_vld && (!pend[k][1] || d_rrdy);
            dw  = dok && (!fok || (losses[k] == maxw[k]));
            fw  = fok && !dw;
            ea  = dw ? d_addr : f_addr;
            g_f[k]  = fw;
            g_d[k]  = dw;
            d_ok[k] = dok;
            chk($sformatf("i%0d_f_req_ready", k), 64'(f_rdy[k]), 64'(fw));
            chk($sformatf("i%0d_d_req_ready", k), 64'(d_rdy[k]), 64'(dw));
            chk($sformatf("i%0d_mem_addr", k),    64'(maddr[k]), 64'(ea));
            chk($sformatf("i%0d_f_rsp_valid", k), 64'(f_rv[k]),  64'(pend[k][0]));
            chk($sformatf("i%0d_f_rsp_data", k),  64'(f_rd[k]),  64'(pend[k][0] ? pdat[k][0] : '0));
            chk($sformatf("i%0d_d_rsp_valid", k), 64'(d_rv[k]),  64'(pend[k][1]));
            chk($sformatf("i%0d_d_rsp_data", k),  64'(d_rd[k]),  64'(pend[k][1] ? pdat[k][1] : '0));
        end
        @(posedge clk_i);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (pend[k][0] && f_rrdy) pend[k][0] = 1'b0;
            if (pend[k][1] && d_rrdy) pend[k][1] = 1'b0;
            if (g_f[k]) begin
                pend[k][0] = 1'b1;
                pdat[k][0] = mem[f_addr];
            end
            if (g_d[k]) begin
                pend[k][1] = 1'b1;
                pdat[k][1] = mem[d_addr];
            end
            if (!d_vld || g_d[k]) losses[k] = 0;
            else if (d_ok[k])     losses[k] = (losses[k] + 1 > maxw[k]) ? maxw[k] : losses[k] + 1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_i%0d_f_req_ready", tag, k), 64'(f_rdy[k]), 64'(0));
            chk($sformatf("%s_i%0d_d_req_ready", tag, k), 64'(d_rdy[k]), 64'(0));
            chk($sformatf("%s_i%0d_f_rsp_valid", tag, k), 64'(f_rv[k]),  64'(0));
            chk($sformatf("%s_i%0d_d_rsp_valid", tag, k), 64'(d_rv[k]),  64'(0));
            chk($sformatf("%s_i%0d_f_rsp_data", tag, k),  64'(f_rd[k]),  64'(0));
            chk($sformatf("%s_i%0d_d_rsp_data", tag, k),  64'(d_rd[k]),  64'(0));
        end
    endtask

    initial begin
        int d_wins0;
        int d_wins1;
        int f_wins1;
        int pick;

        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        model_clear();

        // Reset with requests pending: nothing may be granted.
        rst_n_i = 1'b0;
        set_in(1, 5, 1, 1, 6, 1);
        #2;
        chk_reset_outputs("por");
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;

        // Fetch only, back-to-back from address 0.
        set_in(1, 'h000, 1, 0, 0, 1); step();
        set_in(1, 'h001, 1, 0, 0, 1); step();
        set_in(1, 'h002, 1, 0, 0, 1); step();
        set_in(0, 'h002, 1, 0, 0, 1); step();

        // Both continuously valid: F,F,F,F,D for limit 4; D always for limit 0.
        d_wins0 = 0;
        d_wins1 = 0;
        f_wins1 = 0;
        set_in(1, 'h100, 1, 1, 'h200, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            if (g_d[0]) d_wins0++;
            if (g_d[1]) d_wins1++;
            if (g_f[1]) f_wins1++;
        end
        chk("contend_d_grants_lim4", 64'(d_wins0), 64'(2));
        chk("contend_d_grants_lim0", 64'(d_wins1), 64'(10));
        chk("contend_f_grants_lim0", 64'(f_wins1), 64'(0));
        set_in(0, 0, 1, 0, 0, 1); step();

        // Fetch response back-pressured for 3 cycles, then released
        // together with a new accept.
        set_in(1, 'h010, 1, 0, 0, 1); step();
        set_in(1, 'h011, 0, 0, 0, 1); step();
        set_in(1, 'h011, 0, 0, 0, 1); step();
        set_in(1, 'h011, 0, 0, 0, 1); step();
        set_in(1, 'h011, 1, 0, 0, 1); step();
        set_in(0, 'h011, 1, 0, 0, 1); step();

        // Debug only at the top address.
        set_in(0, 0, 1, 1, 'h3FFF, 1); step();
        set_in(0, 0, 1, 0, 'h3FFF, 1); step();

        // Build up a debug loss streak, then reset mid-flight.
        set_in(1, 'h030, 1, 1, 'h040, 1); step(); step();
        set_in(1, 'h020, 1, 1, 'h040, 1); step();
        rst_n_i = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        model_clear();
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        set_in(0, 'h020, 1, 0, 0, 1); step();
        // Streak must restart from zero after reset.
        set_in(1, 'h050, 1, 1, 'h060, 1);
        for (int i = 0; i < 6; i++) step();

        // Randomized traffic; requests held until instance 0 grants them.
        for (int i = 0; i < 600; i++) begin
            if (!(f_vld && !g_f[0])) begin
                f_vld = ($urandom_range(0, 3) != 0);
                pick  = $urandom_range(0, 9);
                f_addr = (pick == 0) ? '0 : (pick == 1) ? '1 : AW'($urandom);
            end
            if (!(d_vld && !g_d[0])) begin
                d_vld = ($urandom_range(0, 2) != 0);
                pick  = $urandom_range(0, 9);
                d_addr = (pick == 0) ? '0 : (pick == 1) ? '1 : AW'($urandom);
            end
            f_rrdy = ($urandom_range(0, 3) != 0);
            d_rrdy = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
